// File: rtl/toggle_pulse_gen_if.sv
// toggle_pulse_gen_if
//   Bundles the button-side inputs and the status/strobe outputs of the
//   toggle pulse generator.
//   btn_in      : raw asynchronous button level, 1 = pressed
//   enable      : gate for t_out (presses are still counted when low)
//   t_out       : one-cycle toggle strobe per accepted press
//   btn_stable  : debounced button level
//   busy        : high while a level change is being debounced
//   press_count : accepted presses, wraps modulo 2^CNT_W
//   master drives btn_in/enable, slave (the generator) drives the rest.
interface toggle_pulse_gen_if #(
   parameter int CNT_W = 8
);
   logic             btn_in;
   logic             enable;
   logic             t_out;
   logic             btn_stable;
   logic             busy;
   logic [CNT_W-1:0] press_count;

   modport master (
      output btn_in,
      output enable,
      input  t_out,
      input  btn_stable,
      input  busy,
      input  press_count
   );

   modport slave (
      input  btn_in,
      input  enable,
      output t_out,
      output btn_stable,
      output busy,
      output press_count
   );
endinterface

// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen
//   Synchronises and debounces a raw push-button level and emits a single
//   clean toggle strobe per accepted press, for the T flip-flop stage.
//   clk   : system clock, all state on rising edge
//   reset : asynchronous, active-low reset
//   pif   : slave side of toggle_pulse_gen_if (btn_in, enable in;
//           t_out, btn_stable, busy, press_count out, all registered)
module toggle_pulse_gen #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic               clk,
   input  logic               reset,
   toggle_pulse_gen_if.slave  pif
);

   localparam int          DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      DB_PRESS,
      PRESSED,
      DB_RELEASE
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_btn;

   state_t                 state_q, state_d;
   logic [DB_W-1:0]        cnt_q, cnt_d;
   logic                   accept;

   logic                   t_out_q, t_out_d;
   logic                   stable_q, stable_d;
   logic                   busy_q, busy_d;
   logic [CNT_W-1:0]       count_q, count_d;

   // Synchroniser chain; only the last stage is seen by the FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pif.btn_in};
      end
   end

   assign sync_btn = sync_q[SYNC_STAGES-1];

   // State register (FSM state and debounce counter).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. The counter is cleared on every state entry, so a
   // debounce state always starts counting from zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sync_btn) begin
               state_d = DB_PRESS;
               cnt_d   = '0;
            end
         end
         DB_PRESS: begin
            if (!sync_btn) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = PRESSED;
               cnt_d   = '0;
               accept  = 1'b1;
            end else begin
               cnt_d = cnt_q + DB_W'(1);
            end
         end
         PRESSED: begin
            if (!sync_btn) begin
               state_d = DB_RELEASE;
               cnt_d   = '0;
            end
         end
         DB_RELEASE: begin
            if (sync_btn) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + DB_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic. Outputs are decoded from the next state so that the
   // registered values line up with the state they describe.
   always_comb begin
      t_out_d  = accept & pif.enable;
      stable_d = (state_d == PRESSED)  || (state_d == DB_RELEASE);
      busy_d   = (state_d == DB_PRESS) || (state_d == DB_RELEASE);
      count_d  = accept ? count_q + CNT_W'(1) : count_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         t_out_q  <= 1'b0;
         stable_q <= 1'b0;
         busy_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         t_out_q  <= t_out_d;
         stable_q <= stable_d;
         busy_q   <= busy_d;
         count_q  <= count_d;
      end
   end

   assign pif.t_out       = t_out_q;
   assign pif.btn_stable  = stable_q;
   assign pif.busy        = busy_q;
   assign pif.press_count = count_q;

endmodule
